// File: rtl/d1_pkg.sv
// d1_pkg: shared types, default widths and helpers for the day-1 datapath.
// Used by the memory port arbiter and its round-robin picker.
`default_nettype none

package d1_pkg;

   typedef enum logic [0:0] {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   localparam int MEM_AW = 11;
   localparam int MEM_DW = 16;

   // Index width that stays at least one bit wide when there is a single requester.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
// Returns the first asserted request at or above ptr, wrapping to the lowest request.
`default_nettype none

module rr_pick
   import d1_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int PW   = ptr_w(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [PW-1:0]   idx_o
);

   // Descending scan leaves the lowest match in each candidate.
   always_comb begin
      logic          hit_hi;
      logic [PW-1:0] idx_hi;
      logic [PW-1:0] idx_lo;
      hit_hi = 1'b0;
      idx_hi = '0;
      idx_lo = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_lo = PW'(i);
            if (i >= int'(ptr_i)) begin
               idx_hi = PW'(i);
               hit_hi = 1'b1;
            end
         end
      end
      idx_o = hit_hi ? idx_hi : idx_lo;
      gnt_o = (|req_i) ? (NREQ'(1) << idx_o) : '0;
   end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-port synchronous memory,
// with watchdog-bounded port locking and one-cycle tagged read return.
`default_nettype none

module mem_port_arbiter
   import d1_pkg::*;
#(
   parameter int NREQ     = 3,
   parameter int AW       = MEM_AW,
   parameter int DW       = MEM_DW,
   parameter int MAX_LOCK = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_i,
   input  logic [NREQ-1:0]    lock_i,
   input  logic [NREQ-1:0]    we_i,
   input  logic [NREQ*AW-1:0] addr_i,
   input  logic [NREQ*DW-1:0] wdata_i,
   output logic [NREQ-1:0]    gnt_o,
   output logic [NREQ-1:0]    rvalid_o,
   output logic [DW-1:0]      rdata_o,
   output logic [AW-1:0]      mem_addr_o,
   output logic [DW-1:0]      mem_wdata_o,
   output logic               mem_we_o,
   input  logic [DW-1:0]      mem_rdata_i,
   output logic               locked_o,
   output logic               lock_abort_o
);

   localparam int PW = ptr_w(NREQ);
   localparam int CW = $clog2(MAX_LOCK + 1);

   arb_state_t      state_q, state_d;
   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
   logic [NREQ-1:0] rvalid_q;
   logic [AW-1:0]   mem_addr_q;
   logic            locked_q;
   logic            abort_q, abort_d;

   logic [NREQ-1:0] pick_gnt, gnt;
   logic [PW-1:0]   pick_idx, win_idx;
   logic            granted, do_arb;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (int'(p) == NREQ - 1) ? '0 : p + 1'b1;
   endfunction

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr_pick (
      .req_i (req_i),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx)
   );

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      lock_cnt_d = lock_cnt_q;
      abort_d    = 1'b0;
      gnt        = '0;
      win_idx    = pick_idx;
      do_arb     = 1'b0;

      case (state_q)
         LOCKED: begin
            if (req_i[owner_q]) begin
               gnt     = NREQ'(1) << owner_q;
               win_idx = owner_q;
               if (!lock_i[owner_q]) begin
                  state_d    = ARB;
                  lock_cnt_d = '0;
               end else if (lock_cnt_q == CW'(MAX_LOCK)) begin
                  // Watchdog: last grant to the owner, then push it behind everyone else.
                  state_d    = ARB;
                  lock_cnt_d = '0;
                  abort_d    = 1'b1;
                  rr_ptr_d   = next_ptr(owner_q);
               end else begin
                  lock_cnt_d = lock_cnt_q + 1'b1;
               end
            end else begin
               state_d    = ARB;
               lock_cnt_d = '0;
               do_arb     = 1'b1;
            end
         end
         default: do_arb = 1'b1;
      endcase

      if (do_arb && (|req_i)) begin
         gnt      = pick_gnt;
         win_idx  = pick_idx;
         rr_ptr_d = next_ptr(pick_idx);
         if (lock_i[pick_idx]) begin
            state_d    = LOCKED;
            owner_d    = pick_idx;
            lock_cnt_d = CW'(1);
         end
      end

      if (!rst_n) begin
         gnt = '0;
      end
   end

   assign granted      = |gnt;
   assign gnt_o        = gnt;
   assign mem_we_o     = granted & we_i[win_idx];
   assign mem_wdata_o  = granted ? wdata_i[int'(win_idx)*DW +: DW] : '0;
   assign mem_addr_o   = !rst_n  ? '0
                       : granted ? addr_i[int'(win_idx)*AW +: AW]
                       : mem_addr_q;
   assign rdata_o      = mem_rdata_i;
   assign rvalid_o     = rvalid_q;
   assign locked_o     = locked_q;
   assign lock_abort_o = abort_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ARB;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         lock_cnt_q <= '0;
         rvalid_q   <= '0;
         mem_addr_q <= '0;
         locked_q   <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         lock_cnt_q <= lock_cnt_d;
         rvalid_q   <= (granted && !we_i[win_idx]) ? gnt : '0;
         mem_addr_q <= mem_addr_o;
         locked_q   <= (state_d == LOCKED);
         abort_q    <= abort_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the memory port arbiter.
// Instance a uses the default watchdog, instance b a short one; both share stimulus.
`default_nettype none

module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req, lock, we;
   logic [32:0] addr;
   logic [47:0] wdata;

   logic [2:0]  gnt_a, rvalid_a, gnt_b, rvalid_b;
   logic [15:0] rdata_a, rdata_b, mwd_a, mwd_b, mrd_a, mrd_b;
   logic [10:0] maddr_a, maddr_b;
   logic        mwe_a, mwe_b, locked_a, locked_b, abort_a, abort_b;

   logic [15:0] mem_a [0:2047];
   logic [15:0] mem_b [0:2047];

   typedef struct {
      logic [2:0]  who;
      logic [15:0] data;
   } sb_t;
   sb_t         sbq[$];
   logic [15:0] shadow [int];

   logic [10:0] ra [3];
   logic [15:0] rw [3];
   logic [10:0] last_addr;
   int          n_chk  = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   mem_port_arbiter u_dut_a (
      .clk (clk), .rst_n (rst_n), .req_i (req), .lock_i (lock), .we_i (we),
      .addr_i (addr), .wdata_i (wdata), .gnt_o (gnt_a), .rvalid_o (rvalid_a),
      .rdata_o (rdata_a), .mem_addr_o (maddr_a), .mem_wdata_o (mwd_a),
      .mem_we_o (mwe_a), .mem_rdata_i (mrd_a), .locked_o (locked_a),
      .lock_abort_o (abort_a)
   );

   mem_port_arbiter #(.MAX_LOCK (4)) u_dut_b (
      .clk (clk), .rst_n (rst_n), .req_i (req), .lock_i (lock), .we_i (we),
      .addr_i (addr), .wdata_i (wdata), .gnt_o (gnt_b), .rvalid_o (rvalid_b),
      .rdata_o (rdata_b), .mem_addr_o (maddr_b), .mem_wdata_o (mwd_b),
      .mem_we_o (mwe_b), .mem_rdata_i (mrd_b), .locked_o (locked_b),
      .lock_abort_o (abort_b)
   );

   function automatic logic [15:0] dflt(input int a);
      return 16'(a * 37 + 4660);
   endfunction

   // Behavioural memories, reloaded with the default pattern while in reset.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 2048; i++) begin
            mem_a[i] <= dflt(i);
            mem_b[i] <= dflt(i);
         end
      end else begin
         if (mwe_a) mem_a[maddr_a] <= mwd_a;
         if (mwe_b) mem_b[maddr_b] <= mwd_b;
         mrd_a <= mem_a[maddr_a];
         mrd_b <= mem_b[maddr_b];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One clock: drive, then compare grant, memory port and scoreboard against dut a.
   task automatic step(input bit rstv, input logic [2:0] r, input logic [2:0] l,
                       input logic [2:0] w, input logic [2:0] eg, input string tag);
      int          win;
      sb_t         e;
      logic [10:0] ea;
      @(posedge clk);
      #1;
      rst_n = rstv;
      req   = r;
      lock  = l;
      we    = w;
      for (int i = 0; i < 3; i++) begin
         addr[i*11 +: 11]  = ra[i];
         wdata[i*16 +: 16] = rw[i];
      end
      @(negedge clk);
      win = 0;
      for (int i = 0; i < 3; i++) if (eg[i]) win = i;
      check({tag, "/gnt"}, 32'(gnt_a), 32'(eg));
      ea = !rstv ? 11'd0 : (eg != 3'b000) ? ra[win] : last_addr;
      last_addr = ea;
      check({tag, "/maddr"}, 32'(maddr_a), 32'(ea));
      check({tag, "/mwe"}, 32'(mwe_a), (eg != 3'b000) ? 32'(w[win]) : 32'd0);
      check({tag, "/mwdata"}, 32'(mwd_a), (eg != 3'b000) ? 32'(rw[win]) : 32'd0);
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         check({tag, "/rvalid"}, 32'(rvalid_a), 32'(e.who));
         check({tag, "/rdata"}, 32'(rdata_a), 32'(e.data));
      end else begin
         check({tag, "/rv_idle"}, 32'(rvalid_a), 32'd0);
      end
      if (eg != 3'b000) begin
         if (!w[win]) begin
            e.who  = eg;
            e.data = shadow.exists(int'(ra[win])) ? shadow[int'(ra[win])] : dflt(int'(ra[win]));
            sbq.push_back(e);
         end else begin
            shadow[int'(ra[win])] = rw[win];
         end
      end
   endtask

   task automatic set_lock_addrs();
      for (int i = 0; i < 3; i++) begin
         ra[i] = 11'(1000 + i);
         rw[i] = 16'h0;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
      last_addr = '0;
      for (int i = 0; i < 3; i++) begin ra[i] = 11'(i); rw[i] = 16'(i); end

      // Reset: grants forced off even with requests pending.
      for (int k = 0; k < 3; k++) step(1'b0, 3'b111, 3'b000, 3'b000, 3'b000, "reset");
      check("reset/locked", 32'(locked_a), 32'd0);
      check("reset/abort", 32'(abort_a), 32'd0);

      // Round robin over three readers.
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < 3; i++) ra[i] = 11'(16 * k + i + 40);
         step(1'b1, 3'b111, 3'b000, 3'b000, 3'b001 << (k % 3), "rr");
      end
      step(1'b1, 3'b000, 3'b000, 3'b000, 3'b000, "rr_drain");

      // Write by requester 1, read back by requester 2.
      ra[1] = 11'd5; rw[1] = 16'hBEEF; ra[2] = 11'd5;
      step(1'b1, 3'b010, 3'b000, 3'b010, 3'b010, "wr5");
      step(1'b1, 3'b100, 3'b000, 3'b000, 3'b100, "rd5");
      step(1'b1, 3'b000, 3'b000, 3'b000, 3'b000, "rd5_drain");

      // Requester 0 holds the port for ten cycles.
      set_lock_addrs();
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 3'b111, 3'b001, 3'b111, 3'b001, "lock0");
         if (k > 0) check("lock0/locked", 32'(locked_a), 32'd1);
      end
      step(1'b1, 3'b110, 3'b000, 3'b111, 3'b010, "unlock0");
      check("unlock0/locked", 32'(locked_a), 32'd1);
      step(1'b1, 3'b000, 3'b000, 3'b000, 3'b000, "idle_a");
      check("idle_a/locked", 32'(locked_a), 32'd0);
      step(1'b1, 3'b000, 3'b000, 3'b000, 3'b000, "idle_b");

      // Watchdog on instance b: requester 2 locks while requester 0 waits.
      step(1'b1, 3'b100, 3'b100, 3'b111, 3'b100, "wd_enter");
      check("wd_enter/gnt_b", 32'(gnt_b), 32'b100);
      check("wd_enter/locked_b", 32'(locked_b), 32'd0);
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 3'b101, 3'b100, 3'b111, 3'b100, "wd_hold");
         check("wd_hold/gnt_b", 32'(gnt_b), 32'b100);
         check("wd_hold/locked_b", 32'(locked_b), 32'd1);
         check("wd_hold/abort_b", 32'(abort_b), 32'd0);
      end
      step(1'b1, 3'b101, 3'b100, 3'b111, 3'b100, "wd_after");
      check("wd_after/gnt_b", 32'(gnt_b), 32'b001);
      check("wd_after/locked_b", 32'(locked_b), 32'd0);
      check("wd_after/abort_b", 32'(abort_b), 32'd1);
      check("wd_after/abort_a", 32'(abort_a), 32'd0);
      step(1'b1, 3'b000, 3'b000, 3'b000, 3'b000, "wd_end");
      check("wd_end/abort_b", 32'(abort_b), 32'd0);

      // Reset while locked with a read outstanding.
      for (int i = 0; i < 3; i++) begin ra[i] = 11'(20 + i); rw[i] = 16'h0; end
      step(1'b1, 3'b010, 3'b010, 3'b000, 3'b010, "rl_lock");
      ra[1] = 11'd31;
      step(1'b1, 3'b010, 3'b010, 3'b000, 3'b010, "rl_read");
      check("rl_read/locked", 32'(locked_a), 32'd1);
      shadow.delete();
      step(1'b0, 3'b010, 3'b010, 3'b000, 3'b000, "rl_rst");
      step(1'b0, 3'b010, 3'b010, 3'b000, 3'b000, "rl_rst2");
      check("rl_rst2/locked", 32'(locked_a), 32'd0);
      step(1'b1, 3'b111, 3'b000, 3'b000, 3'b001, "rl_first");

      // Idle cycles leave the pointer where it was.
      for (int k = 0; k < 5; k++) step(1'b1, 3'b000, 3'b000, 3'b111, 3'b000, "idle");
      step(1'b1, 3'b111, 3'b000, 3'b000, 3'b010, "idle_next");
      step(1'b1, 3'b000, 3'b000, 3'b000, 3'b000, "final_drain");
      check("final/sb_empty", 32'(sbq.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
